// File: rtl/memory_controller_pkg.sv
// Shared types and constants for the byte-wide memory controller.
package memory_controller_pkg;

    typedef logic [31:0] ADDR_TYPE;
    typedef logic [31:0] INST_TYPE;

    // Access size encodings on lsb_to_mc_len.
    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_READ  = 2'd1,
        LS_READ  = 2'd2,
        LS_WRITE = 2'd3
    } mc_state_t;

    // Value of addr[17:16] that marks the memory-mapped IO window.
    localparam logic [1:0] IO_RANGE = 2'b11;

    function automatic logic is_io(input logic [1:0] region);
        return region == IO_RANGE;
    endfunction

    // Index of the last byte of an access; the unused encoding 2 is treated as a word.
    function automatic logic [1:0] last_byte(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 2'd0;
            LEN_HALF: return 2'd1;
            default:  return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/memory_controller.sv
// Byte-serial memory controller arbitrating instruction fetches and load/store
// requests onto a single 8-bit RAM port.
//
// Handshake: a requester raises its *_to_mc_ready level together with its
// operands and holds all of them stable until the matching mc_to_*_ready
// pulse (exactly one cycle) is seen; the controller never accepts a request
// during the cycle its own done pulse is high. The load/store unit wins over
// fetch when both are pending in the same idle cycle.
//
// Every output is registered. RAM reads are combinational at the RAM; the
// controller captures mem_din on the edge that closes the cycle its address
// was presented in, so the last byte and the done pulse leave on the same edge.
module memory_controller
    import memory_controller_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,

    input  logic       if_to_mc_ready,
    input  ADDR_TYPE   if_to_mc_PC,
    output logic       mc_to_if_ready,
    output INST_TYPE   mc_to_if_inst,

    input  logic       lsb_to_mc_ready,
    input  logic       lsb_to_mc_wr,
    input  ADDR_TYPE   lsb_to_mc_addr,
    input  logic [31:0] lsb_to_mc_data,
    input  logic [1:0] lsb_to_mc_len,
    output logic       mc_to_lsb_ready,
    output logic [31:0] mc_to_lsb_data,

    input  logic       rob_to_mc_clear,

    input  logic [7:0] mem_din,
    output logic [7:0] mem_dout,
    output ADDR_TYPE   mem_a,
    output logic       mem_wr,

    input  logic       io_buffer_full,

    output mc_state_t  state_dbg
);

    mc_state_t   state_q, state_n;
    logic [1:0]  cnt_q, cnt_n;
    logic [1:0]  cnt_inc;
    logic [1:0]  last_q, last_n;
    ADDR_TYPE    addr_q, addr_n;
    logic [31:0] data_q, data_n;
    logic [31:0] buf_q, buf_n;

    ADDR_TYPE    mem_a_n;
    logic [7:0]  mem_dout_n;
    logic        mem_wr_n;
    logic        if_ready_n;
    INST_TYPE    if_inst_n;
    logic        lsb_ready_n;
    logic [31:0] lsb_data_n;

    assign cnt_inc   = cnt_q + 2'd1;
    assign state_dbg = state_q;

    // Next-state, byte sequencing and next-output decode.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        last_n      = last_q;
        addr_n      = addr_q;
        data_n      = data_q;
        buf_n       = buf_q;
        mem_a_n     = '0;
        mem_dout_n  = '0;
        mem_wr_n    = 1'b0;
        if_ready_n  = 1'b0;
        if_inst_n   = mc_to_if_inst;
        lsb_ready_n = 1'b0;
        lsb_data_n  = mc_to_lsb_data;

        case (state_q)
            IDLE: begin
                // A flush in an idle cycle suppresses acceptance entirely.
                if (!rob_to_mc_clear) begin
                    if (lsb_to_mc_ready && !mc_to_lsb_ready) begin
                        addr_n  = lsb_to_mc_addr;
                        data_n  = lsb_to_mc_data;
                        last_n  = last_byte(lsb_to_mc_len);
                        cnt_n   = 2'd0;
                        buf_n   = '0;
                        mem_a_n = lsb_to_mc_addr;
                        if (lsb_to_mc_wr) begin
                            state_n    = LS_WRITE;
                            mem_dout_n = lsb_to_mc_data[7:0];
                            mem_wr_n   = !(is_io(lsb_to_mc_addr[17:16]) && io_buffer_full);
                        end else begin
                            state_n = LS_READ;
                        end
                    end else if (if_to_mc_ready && !mc_to_if_ready) begin
                        state_n = IF_READ;
                        addr_n  = if_to_mc_PC;
                        last_n  = last_byte(LEN_WORD);
                        cnt_n   = 2'd0;
                        buf_n   = '0;
                        mem_a_n = if_to_mc_PC;
                    end
                end
            end

            IF_READ, LS_READ: begin
                if (rob_to_mc_clear) begin
                    state_n = IDLE;
                    cnt_n   = 2'd0;
                end else begin
                    buf_n[{cnt_q, 3'b000} +: 8] = mem_din;
                    if (cnt_q == last_q) begin
                        state_n = IDLE;
                        cnt_n   = 2'd0;
                        if (state_q == IF_READ) begin
                            if_ready_n = 1'b1;
                            if_inst_n  = buf_n;
                        end else begin
                            lsb_ready_n = 1'b1;
                            lsb_data_n  = buf_n;
                        end
                    end else begin
                        cnt_n   = cnt_inc;
                        mem_a_n = addr_q + {30'd0, cnt_inc};
                    end
                end
            end

            LS_WRITE: begin
                // mem_wr high means byte cnt went to RAM this cycle; low means
                // the IO buffer stalled it and it is offered again.
                if (mem_wr) begin
                    if (cnt_q == last_q) begin
                        state_n     = IDLE;
                        cnt_n       = 2'd0;
                        lsb_ready_n = 1'b1;
                    end else begin
                        cnt_n      = cnt_inc;
                        mem_a_n    = addr_q + {30'd0, cnt_inc};
                        mem_dout_n = data_q[{cnt_inc, 3'b000} +: 8];
                        mem_wr_n   = !(is_io(addr_q[17:16]) && io_buffer_full);
                    end
                end else begin
                    mem_a_n    = addr_q + {30'd0, cnt_q};
                    mem_dout_n = data_q[{cnt_q, 3'b000} +: 8];
                    mem_wr_n   = !(is_io(addr_q[17:16]) && io_buffer_full);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset clears everything, rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            last_q          <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            buf_q           <= '0;
            mem_a           <= '0;
            mem_dout        <= '0;
            mem_wr          <= 1'b0;
            mc_to_if_ready  <= 1'b0;
            mc_to_if_inst   <= '0;
            mc_to_lsb_ready <= 1'b0;
            mc_to_lsb_data  <= '0;
        end else if (rdy_in) begin
            state_q         <= state_n;
            cnt_q           <= cnt_n;
            last_q          <= last_n;
            addr_q          <= addr_n;
            data_q          <= data_n;
            buf_q           <= buf_n;
            mem_a           <= mem_a_n;
            mem_dout        <= mem_dout_n;
            mem_wr          <= mem_wr_n;
            mc_to_if_ready  <= if_ready_n;
            mc_to_if_inst   <= if_inst_n;
            mc_to_lsb_ready <= lsb_ready_n;
            mc_to_lsb_data  <= lsb_data_n;
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_memory_controller;
    import memory_controller_pkg::*;

    // ---------------- clock / DUT signals ----------------
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        if_to_mc_ready;
    logic [31:0] if_to_mc_PC;
    logic        mc_to_if_ready;
    logic [31:0] mc_to_if_inst;
    logic        lsb_to_mc_ready, lsb_to_mc_wr;
    logic [31:0] lsb_to_mc_addr, lsb_to_mc_data;
    logic [1:0]  lsb_to_mc_len;
    logic        mc_to_lsb_ready;
    logic [31:0] mc_to_lsb_data;
    logic        rob_to_mc_clear;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    mc_state_t   state_dbg;

    always #5 clk_in = ~clk_in;

    memory_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_to_mc_ready(if_to_mc_ready), .if_to_mc_PC(if_to_mc_PC),
        .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst),
        .lsb_to_mc_ready(lsb_to_mc_ready), .lsb_to_mc_wr(lsb_to_mc_wr),
        .lsb_to_mc_addr(lsb_to_mc_addr), .lsb_to_mc_data(lsb_to_mc_data),
        .lsb_to_mc_len(lsb_to_mc_len),
        .mc_to_lsb_ready(mc_to_lsb_ready), .mc_to_lsb_data(mc_to_lsb_data),
        .rob_to_mc_clear(rob_to_mc_clear),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .state_dbg(state_dbg)
    );

    // ---------------- RAM device (combinational read, clocked write) ----------------
    logic [7:0] ram     [0:65535];
    logic [7:0] ref_mem [0:65535];

    assign mem_din = ram[mem_a[15:0]];

    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One transaction at a time: a fetch/load reads n bytes in n consecutive
    // cycles and completes the cycle after; a store offers byte after byte,
    // an offer counting only if the IO window is not back-pressured.
    localparam int K_FETCH = 0, K_LOAD = 1, K_STORE = 2;

    bit          m_valid = 0;
    bit          m_busy;
    int          m_kind, m_n, m_done;
    logic [31:0] m_addr, m_data, m_result;
    logic [31:0] e_a;
    logic [7:0]  e_dout;
    logic        e_wr, e_if_p, e_lsb_p, e_lsb_ld;
    logic [31:0] e_if_inst, e_lsb_data;
    logic [31:0] n_a;
    logic [7:0]  n_dout;
    logic        n_wr, n_if, n_lsb, wrote;

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic stalled(input logic [31:0] a, input logic full);
        return (a[17:16] == 2'b11) && full;
    endfunction

    always @(posedge clk_in) begin
        // The RAM takes the byte whenever a write is on the port at an edge.
        wrote = m_valid && e_wr;
        if (wrote) ref_mem[e_a[15:0]] = e_dout;
        if (rst_in) begin
            m_valid = 1; m_busy = 0;
            e_a = 0; e_dout = 0; e_wr = 0; e_if_p = 0; e_lsb_p = 0; e_lsb_ld = 0;
            e_if_inst = 0; e_lsb_data = 0;
        end else if (m_valid && rdy_in) begin
            n_a = 0; n_dout = 0; n_wr = 0; n_if = 0; n_lsb = 0;
            if (m_busy && m_kind == K_STORE) begin
                if (wrote) m_done++;
                if (m_done == m_n) begin
                    m_busy = 0; n_lsb = 1; e_lsb_ld = 0;
                end else begin
                    n_a    = m_addr + 32'(m_done);
                    n_dout = m_data[8*m_done +: 8];
                    n_wr   = !stalled(m_addr, io_buffer_full);
                end
            end else if (m_busy) begin
                if (rob_to_mc_clear) begin
                    m_busy = 0;
                end else begin
                    m_result[8*m_done +: 8] = ref_mem[16'(m_addr + 32'(m_done))];
                    m_done++;
                    if (m_done == m_n) begin
                        m_busy = 0;
                        if (m_kind == K_FETCH) begin n_if = 1; e_if_inst = m_result; end
                        else begin n_lsb = 1; e_lsb_ld = 1; e_lsb_data = m_result; end
                    end else begin
                        n_a = m_addr + 32'(m_done);
                    end
                end
            end else if (!rob_to_mc_clear) begin
                if (lsb_to_mc_ready && !e_lsb_p) begin
                    m_busy = 1; m_done = 0; m_result = 0;
                    m_addr = lsb_to_mc_addr; m_data = lsb_to_mc_data;
                    m_n    = nbytes(lsb_to_mc_len);
                    m_kind = lsb_to_mc_wr ? K_STORE : K_LOAD;
                    n_a    = m_addr;
                    if (lsb_to_mc_wr) begin
                        n_dout = m_data[7:0];
                        n_wr   = !stalled(m_addr, io_buffer_full);
                    end
                end else if (if_to_mc_ready && !e_if_p) begin
                    m_busy = 1; m_done = 0; m_result = 0;
                    m_addr = if_to_mc_PC; m_n = 4; m_kind = K_FETCH;
                    n_a    = m_addr;
                end
            end
            e_a = n_a; e_dout = n_dout; e_wr = n_wr; e_if_p = n_if; e_lsb_p = n_lsb;
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk_in) begin
        if (m_valid) begin
            chk("mem_a", mem_a, e_a);
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            if (e_wr) chk("mem_dout", 32'(mem_dout), 32'(e_dout));
            chk("if_pulse", 32'(mc_to_if_ready), 32'(e_if_p));
            chk("lsb_pulse", 32'(mc_to_lsb_ready), 32'(e_lsb_p));
            chk("pulse_excl", 32'(mc_to_if_ready & mc_to_lsb_ready), 32'd0);
            if (e_if_p) chk("if_inst", mc_to_if_inst, e_if_inst);
            if (e_lsb_p && e_lsb_ld) chk("lsb_data", mc_to_lsb_data, e_lsb_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_if(input logic [31:0] pc);
        if_to_mc_ready = 1'b1; if_to_mc_PC = pc;
    endtask

    task automatic drive_lsb(input logic wr, input logic [1:0] len,
                             input logic [31:0] addr, input logic [31:0] data);
        lsb_to_mc_ready = 1'b1; lsb_to_mc_wr = wr; lsb_to_mc_len = len;
        lsb_to_mc_addr = addr; lsb_to_mc_data = data;
    endtask

    task automatic drop_all();
        if_to_mc_ready = 1'b0; lsb_to_mc_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    bit if_drop, lsb_drop;
    int r;

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_to_mc_clear = 1'b0; io_buffer_full = 1'b0;
        if_to_mc_ready = 0; if_to_mc_PC = 0;
        lsb_to_mc_ready = 0; lsb_to_mc_wr = 0; lsb_to_mc_addr = 0;
        lsb_to_mc_data = 0; lsb_to_mc_len = 0;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        begin
            logic [7:0] init_bytes [12];
            logic [15:0] init_addr [12];
            init_bytes = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                           8'h78, 8'h56, 8'h34, 8'h12};
            init_addr  = '{16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005,
                           16'h1006, 16'h1007, 16'h2000, 16'h2001, 16'h2002, 16'h2003};
            for (int i = 0; i < 12; i++) begin
                ram[init_addr[i]] = init_bytes[i];
                ref_mem[init_addr[i]] = init_bytes[i];
            end
        end
        repeat (2) cyc();
        rst_in = 1'b0;
        // Reset values.
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_pulses", {30'd0, mc_to_if_ready, mc_to_lsb_ready}, 32'h0);
        chk("rst_data", mc_to_if_inst | mc_to_lsb_data, 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));

        // Fetch: addresses in T+1..T+4, pulse with 0x00000513 in T+5.
        cyc(); drive_if(32'h1000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("fetch_a", mem_a, 32'h1000 + 32'(i));
        end
        cyc();
        chk("fetch_pulse", 32'(mc_to_if_ready), 32'd1);
        chk("fetch_inst", mc_to_if_inst, 32'h0000_0513);
        cyc();
        chk("fetch_no_reaccept", mem_a, 32'h0);
        drop_all();

        // Contention: LSB load wins, fetch starts right after the LSB pulse.
        cyc(); drive_if(32'h1004); drive_lsb(1'b0, 2'd3, 32'h2000, 32'h0);
        cyc();
        chk("cont_state", 32'(state_dbg), 32'(LS_READ));
        chk("cont_a", mem_a, 32'h2000);
        repeat (4) cyc();
        chk("cont_lsb_pulse", 32'(mc_to_lsb_ready), 32'd1);
        chk("cont_lsb_data", mc_to_lsb_data, 32'h1234_5678);
        cyc();
        lsb_to_mc_ready = 1'b0;
        chk("cont_if_start", mem_a, 32'h1004);
        chk("cont_if_state", 32'(state_dbg), 32'(IF_READ));
        repeat (4) cyc();
        chk("cont_if_pulse", 32'(mc_to_if_ready), 32'd1);
        chk("cont_if_inst", mc_to_if_inst, 32'h0010_0093);
        cyc(); drop_all();

        // Half store at 0x3002.
        cyc(); drive_lsb(1'b1, 2'd1, 32'h3002, 32'hABCD_1234);
        cyc();
        chk("st_b0", {mem_a[23:0], mem_dout}, {24'h003002, 8'h34});
        chk("st_wr0", 32'(mem_wr), 32'd1);
        cyc();
        chk("st_b1", {mem_a[23:0], mem_dout}, {24'h003003, 8'h12});
        chk("st_wr1", 32'(mem_wr), 32'd1);
        cyc();
        chk("st_pulse", 32'(mc_to_lsb_ready), 32'd1);
        cyc(); drop_all();

        // IO stall: full during the acceptance cycle and the two after it.
        cyc(); drive_lsb(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A); io_buffer_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("io_stall_wr", 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        cyc();
        chk("io_write", {mem_a[23:0], mem_dout}, {24'h030000, 8'h5A});
        chk("io_write_wr", 32'(mem_wr), 32'd1);
        cyc();
        chk("io_pulse", 32'(mc_to_lsb_ready), 32'd1);
        cyc(); drop_all();

        // Flush during a fetch aborts it.
        cyc(); drive_if(32'h1000);
        repeat (2) cyc();
        rob_to_mc_clear = 1'b1; if_to_mc_ready = 1'b0;
        cyc();
        rob_to_mc_clear = 1'b0;
        chk("flush_idle", 32'(state_dbg), 32'(IDLE));
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("flush_no_pulse", 32'(mc_to_if_ready), 32'd0);
        end

        // Flush during a store has no effect.
        cyc(); drive_lsb(1'b1, 2'd3, 32'h3100, 32'hCAFE_F00D);
        cyc();
        rob_to_mc_clear = 1'b1;
        cyc();
        rob_to_mc_clear = 1'b0;
        chk("flush_st_b1", {mem_a[23:0], mem_dout}, {24'h003101, 8'hF0});
        repeat (2) cyc();
        chk("flush_st_b3", {mem_a[23:0], mem_dout}, {24'h003103, 8'hCA});
        cyc();
        chk("flush_st_pulse", 32'(mc_to_lsb_ready), 32'd1);
        cyc(); drop_all();

        // Reset in the middle of a load.
        cyc(); drive_lsb(1'b0, 2'd3, 32'h2000, 32'h0);
        repeat (3) cyc();
        rst_in = 1'b1; drop_all();
        cyc();
        rst_in = 1'b0;
        chk("mid_rst_outs", {mem_a | mc_to_lsb_data | mc_to_if_inst}, 32'h0);
        chk("mid_rst_ctl", {29'd0, mem_wr, mc_to_if_ready, mc_to_lsb_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mid_rst_no_pulse", 32'(mc_to_lsb_ready), 32'd0);
        end

        // rdy_in low for two cycles mid-fetch: pulse slips to T+7.
        cyc(); drive_if(32'h1000);
        repeat (2) cyc();
        rdy_in = 1'b0;
        repeat (2) cyc();
        rdy_in = 1'b1;
        cyc();
        chk("rdy_no_pulse5", 32'(mc_to_if_ready), 32'd0);
        cyc();
        chk("rdy_no_pulse6", 32'(mc_to_if_ready), 32'd0);
        cyc();
        chk("rdy_pulse7", 32'(mc_to_if_ready), 32'd1);
        chk("rdy_inst", mc_to_if_inst, 32'h0000_0513);
        cyc(); drop_all();

        // Randomized traffic.
        if_drop = 0; lsb_drop = 0;
        for (int c = 0; c < 4000; c++) begin
            if (if_drop)  begin if_to_mc_ready = 1'b0;  if_drop = 0;  end
            if (lsb_drop) begin lsb_to_mc_ready = 1'b0; lsb_drop = 0; end
            if (mc_to_if_ready)  if_drop = 1;
            if (mc_to_lsb_ready) lsb_drop = 1;
            if (!if_to_mc_ready && !if_drop && $urandom_range(0, 2) == 0)
                drive_if({20'd0, 10'($urandom_range(0, 1023)), 2'b00});
            if (!lsb_to_mc_ready && !lsb_drop && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 7);
                drive_lsb(1'($urandom),
                          ($urandom_range(0, 2) == 0) ? 2'd0 : ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3,
                          (r == 0) ? {14'd0, 2'b11, 16'($urandom)} :
                          (r == 1) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) :
                                     32'($urandom_range(0, 4095)),
                          $urandom);
            end
            io_buffer_full  = ($urandom_range(0, 3) == 0);
            rdy_in          = ($urandom_range(0, 9) != 0);
            rob_to_mc_clear = ($urandom_range(0, 24) == 0);
            if (rob_to_mc_clear) begin
                if_to_mc_ready = 1'b0;
                if (!lsb_to_mc_wr) lsb_to_mc_ready = 1'b0;
            end
            rst_in = ($urandom_range(0, 299) == 0);
            if (rst_in) drop_all();
            cyc();
        end
        rst_in = 1'b0; rdy_in = 1'b1; rob_to_mc_clear = 1'b0; io_buffer_full = 1'b0;
        drop_all();
        repeat (10) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have ports: clk_in  in  1  system clock; one clock domain only.
REQ-002 SHALL have port rst_in  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port rdy_in  in  1  global enable; while low, all state and outputs are frozen.
REQ-004 SHALL have ports if_to_mc_ready in 1 (fetch request valid, level) and if_to_mc_PC in 32 (word-aligned fetch address).
REQ-005 SHALL have ports mc_to_if_ready out 1 (one-cycle done pulse) and mc_to_if_inst out 32 (fetched instruction, valid with the pulse).
REQ-006 SHALL have ports lsb_to_mc_ready in 1 (request valid), lsb_to_mc_wr in 1 (1 = store), lsb_to_mc_addr in 32, lsb_to_mc_data in 32 and lsb_to_mc_len in 2 (0 = byte, 1 = half, 3 = word).
REQ-007 SHALL have ports mc_to_lsb_ready out 1 (one-cycle done pulse) and mc_to_lsb_data out 32 (load data, zero-extended).
REQ-008 SHALL have port rob_to_mc_clear in 1, a misprediction flush pulse.
REQ-009 SHALL have ports mem_din in 8, mem_dout out 8, mem_a out 32 and mem_wr out 1 (1 = write); this is the byte-wide RAM port.
REQ-010 SHALL have port io_buffer_full in 1; while high, writes to the IO range are not allowed.

Function
REQ-011 SHALL implement states IDLE, IF_READ, LS_READ and LS_WRITE with a 2-bit byte counter cnt.
REQ-012 In IDLE, a pending LSB request SHALL win over a pending IF request sampled in the same cycle; the IF request stays pending and is served next.
REQ-013 On acceptance in cycle T, the block SHALL latch addr, len, data and wr, and move to the target state.
REQ-014 Read address timing: in cycles T+1..T+n the block SHALL drive mem_a = addr+cnt with mem_wr = 0, where n = len+1 (n = 4 for fetches).
REQ-015 Read data capture: mem_din SHALL be sampled one cycle after its address.
REQ-016 Read byte placement: byte k SHALL go to result bits [8k+7:8k] (little-endian).
REQ-017 Read completion: the done pulse and data SHALL be driven in cycle T+n+1, so fetch latency is 5 cycles; the state then returns to IDLE.
REQ-018 Write timing: in cycles T+1..T+n the block SHALL drive mem_wr = 1, mem_a = addr+cnt and mem_dout = data[8cnt+7:8cnt].
REQ-019 Write completion: mc_to_lsb_ready SHALL pulse in cycle T+n+1.
REQ-020 IO-range writes (addr[17:16] == 2'b11) with io_buffer_full high SHALL hold mem_wr = 0 and hold cnt until io_buffer_full falls; the completion pulse shifts later by the same number of cycles.
REQ-021 When not writing, mem_wr SHALL be 0, and mem_a SHALL be 0 in IDLE.
REQ-022 Each done pulse SHALL last exactly one cycle; mc_to_if_ready and mc_to_lsb_ready SHALL never be high together.
REQ-023 rob_to_mc_clear in IF_READ or LS_READ SHALL abort to IDLE next cycle with no done pulse.
REQ-024 rob_to_mc_clear in LS_WRITE SHALL have no effect; the committed store always completes.
REQ-025 rob_to_mc_clear in IDLE SHALL block acceptance of any request in that same cycle.
REQ-026 Requesters SHALL hold their request until the done pulse; the block SHALL not re-accept during the pulse cycle.
REQ-027 Address arithmetic SHALL be 32-bit and wrap modulo 2^32.

Reset
REQ-028 While rst_in is high at a clock edge, the block SHALL set state to IDLE, cnt to 0, and all outputs (ready pulses, data, mem_a, mem_dout, mem_wr) to 0.
REQ-029 Reset asserted mid-transaction SHALL discard that transaction without a done pulse.
REQ-030 Reset SHALL take priority over rdy_in and rob_to_mc_clear.

Structure
REQ-031 Shared package SHALL hold ADDR_TYPE, INST_TYPE, the len encodings, the state encodings and the IO_RANGE constant.
REQ-032 Single module SHALL be used with no sub-modules; byte assembly and split logic SHALL be inline.

Verification
REQ-033 Fetch: IF PC=0x1000 with RAM bytes 13,05,00,00 -> mem_a 0x1000..0x1003 in T+1..T+4, then mc_to_if_inst = 0x00000513 with a pulse at T+5.
REQ-034 Contention: IF and LSB word load (addr 0x2000) raised in the same cycle -> LSB served first, then IF starts in the cycle after the LSB pulse.
REQ-035 Store: half store addr=0x3002, data=0xABCD1234 -> mem_wr = 1 with (0x3002, 0x34) then (0x3003, 0x12), followed by an LSB pulse.
REQ-036 IO stall: byte store to 0x30000 with io_buffer_full high for 3 cycles -> no mem_wr during the stall, write occurs after it, and the pulse is delayed by 3 cycles.
REQ-037 Flush: clear at T+2 of a fetch -> IDLE at T+3 with no mc_to_if_ready; clear during a store -> the store completes unchanged.
REQ-038 Reset and rdy: rst_in at T+3 of a load -> all outputs 0 with no pulse; rdy_in low for 2 cycles mid-fetch -> the pulse slips by 2 cycles with correct data.
